// File: rtl/bcd_pkg.sv
// Shared BCD digit type, range constants and digit validity helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    function automatic logic bcd_valid(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_counter_if.sv
// Control/status bundle of the BCD counter; master drives controls, slave is the counter.
interface bcd_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic                  tick;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output en, up, clear, load, load_val,
        input  bcd, tick, wrap, load_err
    );

    modport slave (
        input  en, up, clear, load, load_val,
        output bcd, tick, wrap, load_err
    );
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit register of the ripple chain: load/clear, inc/dec on carry-in, carry/borrow out.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       load_i,
    input  bcd_digit_t load_val_i,
    input  logic       apply_i,
    input  logic       up_i,
    input  logic       cin_i,
    output bcd_digit_t digit_o,
    output logic       cout_o
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;
    bcd_digit_t eff_s;

    // Next digit value and carry/borrow; an out-of-range digit behaves as zero.
    always_comb begin
        eff_s   = bcd_valid(digit_q) ? digit_q : BCD_ZERO;
        cout_o  = cin_i && (up_i ? (eff_s == BCD_MAX) : (eff_s == BCD_ZERO));
        digit_d = digit_q;
        if (clear_i) begin
            digit_d = BCD_ZERO;
        end else if (load_i) begin
            digit_d = bcd_valid(load_val_i) ? load_val_i : BCD_ZERO;
        end else if (apply_i && cin_i) begin
            if (up_i) begin
                digit_d = (eff_s == BCD_MAX) ? BCD_ZERO : eff_s + 4'd1;
            end else begin
                digit_d = (eff_s == BCD_ZERO) ? BCD_MAX : eff_s - 4'd1;
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with tick prescaler.
// Optional macro BCD_COUNTER_SATURATE_EN: saturate at all-9/all-0 instead of wrapping.
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000000
) (
    input  logic          clk,
    input  logic          rst,
    bcd_counter_if.slave  bus
);

    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]       pre_q;
    logic [PW-1:0]       pre_d;
    logic                tick_q;
    logic                tick_d;
    logic                wrap_q;
    logic                wrap_d;
    logic                load_err_q;
    logic                load_err_d;
    logic                step_s;
    logic                apply_s;
    logic                boundary_s;
    logic [DIGITS:0]     carry_s;
    logic [DIGITS-1:0]   bad_s;
    logic [4*DIGITS-1:0] bcd_s;
    bcd_digit_t          digits_s [DIGITS];

    // Chain probe starts at 1 so the top carry flags a full-range crossing independent of apply.
    assign carry_s[0]  = 1'b1;
    assign boundary_s  = carry_s[DIGITS];
    assign step_s      = bus.en && (pre_q == PRE_LAST) && !bus.clear && !bus.load;

`ifdef BCD_COUNTER_SATURATE_EN
    assign apply_s = step_s && !boundary_s;
`else
    assign apply_s = step_s;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .clear_i    (bus.clear),
            .load_i     (bus.load),
            .load_val_i (bus.load_val[4*g +: 4]),
            .apply_i    (apply_s),
            .up_i       (bus.up),
            .cin_i      (carry_s[g]),
            .digit_o    (digits_s[g]),
            .cout_o     (carry_s[g+1])
        );
        assign bcd_s[4*g +: 4] = digits_s[g];
        assign bad_s[g]        = !bcd_valid(bus.load_val[4*g +: 4]);
    end

    // Prescaler phase and status-pulse next state; clear beats load beats count.
    always_comb begin
        pre_d      = pre_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.clear) begin
            pre_d = '0;
        end else if (bus.load) begin
            pre_d      = '0;
            load_err_d = |bad_s;
        end else if (bus.en) begin
            pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
            tick_d = step_s;
            wrap_d = step_s && boundary_s;
        end else begin
            pre_d = pre_q;
        end
    end

    // Prescaler and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q      <= '0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.bcd      = bcd_s;
    assign bus.tick     = tick_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Randomized bench for bcd_counter against an integer-valued reference model.
module tb_bcd_counter;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;
    localparam int MAXV     = 99;
`ifdef BCD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;

    bcd_counter_if #(.DIGITS(DIGITS)) bus ();

    bcd_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_chk;
    int m_val;
    int m_pre;
    bit m_tick;
    bit m_wrap;
    bit m_lerr;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: counter value held as a plain integer 0..MAXV.
    task automatic model_edge();
        int   w;
        int   d;
        bit   bad;
        logic [4*DIGITS-1:0] lv;
        if (!rst) begin
            m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0; m_lerr = 0;
        end else if (bus.clear) begin
            m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0; m_lerr = 0;
        end else if (bus.load) begin
            lv  = bus.load_val;
            bad = 0;
            m_val = 0;
            w = 1;
            for (int i = 0; i < DIGITS; i++) begin
                d = int'(lv[4*i +: 4]);
                if (d > 9) begin
                    bad = 1;
                    d = 0;
                end
                m_val = m_val + d * w;
                w = w * 10;
            end
            m_lerr = bad; m_pre = 0; m_tick = 0; m_wrap = 0;
        end else begin
            m_tick = 0; m_wrap = 0; m_lerr = 0;
            if (bus.en) begin
                if (m_pre == PRESCALE - 1) begin
                    m_pre  = 0;
                    m_tick = 1;
                    if (bus.up) begin
                        if (m_val == MAXV) begin
                            m_wrap = 1;
                            m_val  = SAT ? MAXV : 0;
                        end else begin
                            m_val = m_val + 1;
                        end
                    end else begin
                        if (m_val == 0) begin
                            m_wrap = 1;
                            m_val  = SAT ? 0 : MAXV;
                        end else begin
                            m_val = m_val - 1;
                        end
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk_val("bcd", 32'(bus.bcd), 32'(to_bcd(m_val)));
        chk_val("tick", 32'(bus.tick), 32'(m_tick));
        chk_val("wrap", 32'(bus.wrap), 32'(m_wrap));
        chk_val("load_err", 32'(bus.load_err), 32'(m_lerr));
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] v);
        bus.load = 1'b1;
        bus.load_val = v;
        cyc();
        bus.load = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_chk = 0;
        m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0; m_lerr = 0;
        rst = 1'b0;
        bus.en = 1'b0; bus.up = 1'b0; bus.clear = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        repeat (3) cyc();
        chk_val("reset_bcd", 32'(bus.bcd), 32'h0);

        // Basic counting cadence after release.
        bus.en = 1'b1; bus.up = 1'b1; rst = 1'b1;
        repeat (3) cyc();
        chk_val("t1_no_tick_early", 32'(bus.tick), 32'h0);
        cyc();
        chk_val("t1_first_bcd", 32'(bus.bcd), 32'h01);
        chk_val("t1_first_tick", 32'(bus.tick), 32'h1);
        repeat (4) cyc();
        chk_val("t1_second_bcd", 32'(bus.bcd), 32'h02);

        // Up wrap and carry.
        do_load(8'h99);
        repeat (4) cyc();
        chk_val("t2_wrap_bcd", 32'(bus.bcd), SAT ? 32'h99 : 32'h00);
        chk_val("t2_wrap", 32'(bus.wrap), 32'h1);
        cyc();
        chk_val("t2_wrap_one_cycle", 32'(bus.wrap), 32'h0);
        do_load(8'h09);
        repeat (4) cyc();
        chk_val("t2_carry_bcd", 32'(bus.bcd), 32'h10);
        chk_val("t2_carry_nowrap", 32'(bus.wrap), 32'h0);

        // Down borrow and wrap.
        bus.up = 1'b0;
        do_load(8'h00);
        repeat (4) cyc();
        chk_val("t3_down_wrap_bcd", 32'(bus.bcd), SAT ? 32'h00 : 32'h99);
        chk_val("t3_down_wrap", 32'(bus.wrap), 32'h1);
        do_load(8'h10);
        repeat (4) cyc();
        chk_val("t3_borrow_bcd", 32'(bus.bcd), 32'h09);

        // Invalid load digits and clear-over-load priority.
        do_load(8'h3C);
        chk_val("t4_load_bcd", 32'(bus.bcd), 32'h30);
        chk_val("t4_load_err", 32'(bus.load_err), 32'h1);
        cyc();
        chk_val("t4_load_err_pulse", 32'(bus.load_err), 32'h0);
        bus.clear = 1'b1;
        do_load(8'h3C);
        bus.clear = 1'b0;
        chk_val("t4_clear_bcd", 32'(bus.bcd), 32'h00);
        chk_val("t4_clear_lerr", 32'(bus.load_err), 32'h0);

        // Enable freezes the prescaler phase.
        bus.up = 1'b1;
        repeat (2) cyc();
        bus.en = 1'b0;
        repeat (10) cyc();
        chk_val("t5_frozen_bcd", 32'(bus.bcd), 32'h00);
        bus.en = 1'b1;
        cyc();
        chk_val("t5_no_tick_yet", 32'(bus.tick), 32'h0);
        cyc();
        chk_val("t5_tick_resume", 32'(bus.tick), 32'h1);
        chk_val("t5_bcd_resume", 32'(bus.bcd), 32'h01);

        // Asynchronous reset mid-prescale.
        do_load(8'h57);
        repeat (2) cyc();
        #2;
        rst = 1'b0;
        #1;
        m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0; m_lerr = 0;
        chk_val("t6_async_bcd", 32'(bus.bcd), 32'h0);
        chk_val("t6_async_tick", 32'(bus.tick), 32'h0);
        chk_val("t6_async_wrap", 32'(bus.wrap), 32'h0);
        repeat (2) cyc();
        rst = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.clear    = ($urandom_range(31) == 0);
            bus.load     = ($urandom_range(15) == 0);
            bus.load_val = 8'($urandom);
            bus.en       = ($urandom_range(3) != 0);
            bus.up       = ($urandom_range(1) == 1);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
